// File: rtl/am2930_prefetch_q_pkg.sv
// am2930_prefetch_q_pkg: shared FSM encodings and am2930 opcode constants for the prefetch queue.
package am2930_prefetch_q_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [4:0] PSUS = 5'b11111;
  localparam logic [4:0] PRST = 5'b00000;
endpackage

// File: rtl/am29_sync_fifo.sv
// am29_sync_fifo: in-order storage with head/tail pointers, occupancy count and flush.
module am29_sync_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic do_rd;
  assign do_rd = rd && count != '0;
  assign rdata = mem[head];
  always_ff @(posedge clk)
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (do_rd) head <= head + 1'b1;
      count <= count + CW'(wr) - CW'(do_rd);
    end
  always_ff @(posedge clk)
    if (wr && !rst && !flush) mem[tail] <= wdata;
endmodule

// File: rtl/am2930_prefetch_q.sv
// am2930_prefetch_q: am2930 PCU prefetch queue with ien_ throttle and branch flush.
// Define PREFETCH_BYPASS_EN to forward an ack straight to ir when the queue is empty.
module am2930_prefetch_q
  import am2930_prefetch_q_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          cp,
  input  logic          rst,
  input  logic [AW-1:0] y,
  input  logic          y_valid,
  input  logic          flush,
  output logic          ien_,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_ack,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_addr,
  output logic          ir_valid,
  input  logic          ir_take,
  output logic [CW-1:0] count,
  output logic          empty_,
  output logic          full_
);
  logic [1:0] state;
  logic push, pop, acc, wr;
  logic [CW:0] cnt_next;
  logic [AW+DW-1:0] head;
  assign push = state == REQ && mem_ack && !flush;
  assign pop = ir_take && ir_valid;
  assign cnt_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign acc = !rst && !flush && y_valid && (state == IDLE || (state == REQ && mem_ack))
               && cnt_next < (CW+1)'(DEPTH);
  assign ien_ = !acc;
  assign mem_rd = state == REQ;
  assign empty_ = count != '0;
  assign full_ = count != CW'(DEPTH);
`ifdef PREFETCH_BYPASS_EN
  logic byp;
  assign byp = push && count == '0;
  assign wr = push && !(byp && ir_take);
  assign ir_valid = count != '0 || byp;
  assign {ir_addr, ir} = byp ? {mem_addr, mem_data} : head;
`else
  assign wr = push;
  assign ir_valid = count != '0;
  assign {ir_addr, ir} = head;
`endif
  am29_sync_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
    .clk(cp), .rst(rst), .flush(flush), .wr(wr), .wdata({mem_addr, mem_data}),
    .rd(ir_take), .rdata(head), .count(count)
  );
  // An ack always closes the read; flush without ack leaves it outstanding as DISCARD.
  always_ff @(posedge cp)
    if (rst) begin
      state <= IDLE;
      mem_addr <= '0;
    end else if (acc) begin
      state <= REQ;
      mem_addr <= y;
    end else if (state == REQ) state <= mem_ack ? IDLE : (flush ? DISCARD : REQ);
    else if (state == DISCARD && mem_ack) state <= IDLE;
endmodule

// File: tb/tb_am2930_prefetch_q.sv
// tb_am2930_prefetch_q: randomized scoreboard bench against a queue-level reference model.
module tb_am2930_prefetch_q;
  localparam int DEPTH = 4;
  logic cp = 0, rst = 1;
  logic [3:0] y = 0;
  logic y_valid = 0, flush = 0, mem_ack = 0, ir_take = 0;
  logic [15:0] mem_data = 0;
  logic ien_, mem_rd, ir_valid, empty_, full_;
  logic [3:0] mem_addr, ir_addr;
  logic [15:0] ir;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [19:0] exp_q[$];
  bit busy = 0, stale = 0;
  int qsize = 0;
  logic [3:0] m_addr = 0;

  always #5 cp = ~cp;

  am2930_prefetch_q #(.AW(4), .DW(16), .DEPTH(DEPTH)) dut (
    .cp(cp), .rst(rst), .y(y), .y_valid(y_valid), .flush(flush), .ien_(ien_),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
    .ir(ir), .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_take(ir_take),
    .count(count), .empty_(empty_), .full_(full_)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge cp)
    if (ir_valid === 1'b1 && ir_take) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_pop: got %0h expected nothing (model queue empty)", {ir_addr, ir});
      end else chk("head", {ir_addr, ir}, exp_q.pop_front());
    end

  task automatic step(input logic r, input logic [3:0] yi, input logic yv, input logic fl,
                      input logic ak, input logic [15:0] d, input logic tk, output bit acc);
    bit push, pop, vld;
    int nxt;
    @(posedge cp);
    #1;
    rst = r; y = yi; y_valid = yv; flush = fl; mem_ack = ak; mem_data = d; ir_take = tk;
    #3;
    acc = 0;
    if (r) begin
      chk("ien_rst", ien_, 1);
      busy = 0; stale = 0; qsize = 0; m_addr = 0;
      exp_q.delete();
    end else begin
      push = busy && !stale && ak && !fl;
      vld = qsize > 0;
`ifdef PREFETCH_BYPASS_EN
      vld = vld || push;
`endif
      pop = tk && vld;
      nxt = qsize + int'(push) - int'(pop);
      acc = !fl && yv && (!busy || (!stale && ak)) && nxt < DEPTH;
      chk("ien_", ien_, !acc);
      chk("mem_rd", mem_rd, busy && !stale);
      chk("mem_addr", mem_addr, m_addr);
      chk("count", count, qsize);
      chk("ir_valid", ir_valid, vld);
      chk("empty_", empty_, qsize != 0);
      chk("full_", full_, qsize != DEPTH);
      if (push) exp_q.push_back({m_addr, d});
      if (fl) begin
        qsize = 0;
        exp_q.delete();
      end else qsize = nxt;
      // Reference: one read at a time; a flushed read stays stale until its ack.
      if (busy && stale) begin
        if (ak) begin busy = 0; stale = 0; end
      end else if (busy) begin
        if (fl) begin
          if (ak) busy = 0; else stale = 1;
        end else if (acc) m_addr = yi;
        else if (ak) busy = 0;
      end else if (acc) begin
        busy = 1;
        m_addr = yi;
      end
    end
  endtask

  initial begin
    bit a;
    logic [3:0] ya;
    step(1, 0, 1, 0, 0, 0, 0, a);
    step(1, 0, 1, 0, 0, 0, 0, a);
    step(0, 4'b0011, 1, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 16'hA5C3, 0, a);
    step(0, 0, 0, 0, 0, 0, 1, a);
    ya = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, ya, 1, 0, busy, 16'h1000 + 16'(i), 0, a);
      if (a) ya++;
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, a);
    step(0, 4'b0111, 1, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 0, 0, 0, a);
    step(0, 4'b1000, 1, 0, 0, 0, 0, a);
    step(0, 4'b1000, 1, 0, 1, 16'hDEAD, 0, a);
    step(0, 4'b1000, 1, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 16'h0808, 1, a);
    step(0, 4'h9, 1, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 1, 16'hBEEF, 0, a);
    step(0, 0, 0, 0, 0, 0, 1, a);
    for (int i = 0; i < 3000; i++) begin
      bit fl, yv, ak, tk, r;
      r = $urandom_range(0, 199) == 0;
      fl = $urandom_range(0, 15) == 0;
      yv = $urandom_range(0, 3) != 0;
      ak = busy ? $urandom_range(0, 2) != 0 : $urandom_range(0, 7) == 0;
      tk = !fl && !r && $urandom_range(0, 1) == 1;
      step(r, 4'($urandom), yv, fl, ak, 16'($urandom), tk, a);
    end
    step(0, 0, 0, 0, 0, 0, 0, a);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
